// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the EXE-stage divider sequencer.
package div_sequencer_pkg;

  localparam int DW_DEFAULT = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_result_cache.sv
// Single-entry cache of the last completed divide, so a mod that follows a div
// on the same operands skips the core. Instantiated only under DIV_CACHE_EN.
module div_result_cache
  import div_sequencer_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          fill_i,
  input  logic          fill_signed_i,
  input  logic [DW-1:0] fill_src1_i,
  input  logic [DW-1:0] fill_src2_i,
  input  logic [DW-1:0] fill_quo_i,
  input  logic [DW-1:0] fill_rem_i,
  input  logic          lookup_signed_i,
  input  logic [DW-1:0] lookup_src1_i,
  input  logic [DW-1:0] lookup_src2_i,
  output logic          hit_o,
  output logic [DW-1:0] hit_quo_o,
  output logic [DW-1:0] hit_rem_o
);

  logic          valid_q;
  logic          signed_q;
  logic [DW-1:0] src1_q;
  logic [DW-1:0] src2_q;
  logic [DW-1:0] quo_q;
  logic [DW-1:0] rem_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      signed_q <= 1'b0;
      src1_q   <= '0;
      src2_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
    end else if (fill_i) begin
      valid_q  <= 1'b1;
      signed_q <= fill_signed_i;
      src1_q   <= fill_src1_i;
      src2_q   <= fill_src2_i;
      quo_q    <= fill_quo_i;
      rem_q    <= fill_rem_i;
    end
  end

  assign hit_o = valid_q && (signed_q == lookup_signed_i) &&
                 (src1_q == lookup_src1_i) && (src2_q == lookup_src2_i);
  assign hit_quo_o = quo_q;
  assign hit_rem_o = rem_q;

endmodule

// File: rtl/div_sequencer.sv
// Sequences one div/mod request onto the signed/unsigned divider cores and holds
// the result for EXE; drains stale results on flush. DIV_CACHE_EN adds a result cache.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid_i,
  input  logic            req_signed_i,
  input  logic            req_mod_i,
  input  logic [DW-1:0]   req_src1_i,
  input  logic [DW-1:0]   req_src2_i,
  input  logic            flush_i,
  input  logic            res_ack_i,
  output logic            res_valid_o,
  output logic [DW-1:0]   res_data_o,
  output logic            busy_o,
  output logic [DW-1:0]   div_src1_o,
  output logic [DW-1:0]   div_src2_o,
  output logic            sdiv_tvalid_o,
  output logic            udiv_tvalid_o,
  input  logic            sdiv_tready_i,
  input  logic            udiv_tready_i,
  input  logic            sdiv_dout_valid_i,
  input  logic            udiv_dout_valid_i,
  input  logic [2*DW-1:0] sdiv_dout_i,
  input  logic [2*DW-1:0] udiv_dout_i
);

  div_state_e    state_q, state_d;
  logic          kill_q, kill_d;
  logic          signed_q, signed_d;
  logic          mod_q, mod_d;
  logic [DW-1:0] src1_q, src1_d;
  logic [DW-1:0] src2_q, src2_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [DW-1:0] rem_q, rem_d;

  logic            sel_tready;
  logic            sel_dout_valid;
  logic [2*DW-1:0] sel_dout;

  assign sel_tready     = signed_q ? sdiv_tready_i     : udiv_tready_i;
  assign sel_dout_valid = signed_q ? sdiv_dout_valid_i : udiv_dout_valid_i;
  assign sel_dout       = signed_q ? sdiv_dout_i       : udiv_dout_i;

`ifdef DIV_CACHE_EN
  logic          cache_hit;
  logic [DW-1:0] cache_quo;
  logic [DW-1:0] cache_rem;
  logic          cache_fill;

  // Only a clean WAIT->DONE completion may populate the cache.
  assign cache_fill = (state_q == S_WAIT) && sel_dout_valid && !flush_i;

  div_result_cache #(.DW(DW)) u_cache (
    .clk             (clk),
    .reset           (reset),
    .fill_i          (cache_fill),
    .fill_signed_i   (signed_q),
    .fill_src1_i     (src1_q),
    .fill_src2_i     (src2_q),
    .fill_quo_i      (sel_dout[2*DW-1:DW]),
    .fill_rem_i      (sel_dout[DW-1:0]),
    .lookup_signed_i (req_signed_i),
    .lookup_src1_i   (req_src1_i),
    .lookup_src2_i   (req_src2_i),
    .hit_o           (cache_hit),
    .hit_quo_o       (cache_quo),
    .hit_rem_o       (cache_rem)
  );
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      kill_q   <= 1'b0;
      signed_q <= 1'b0;
      mod_q    <= 1'b0;
      src1_q   <= '0;
      src2_q   <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      kill_q   <= kill_d;
      signed_q <= signed_d;
      mod_q    <= mod_d;
      src1_q   <= src1_d;
      src2_q   <= src2_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    kill_d   = kill_q;
    signed_d = signed_q;
    mod_d    = mod_q;
    src1_d   = src1_q;
    src2_d   = src2_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && !flush_i) begin
          signed_d = req_signed_i;
          mod_d    = req_mod_i;
          src1_d   = req_src1_i;
          src2_d   = req_src2_i;
          state_d  = S_ISSUE;
`ifdef DIV_CACHE_EN
          if (cache_hit) begin
            quo_d   = cache_quo;
            rem_d   = cache_rem;
            state_d = S_DONE;
          end
`endif
        end
      end
      // The handshake must complete even when killed, or the core would be left mid-transfer.
      S_ISSUE: begin
        if (sel_tready) begin
          if (kill_q || flush_i) begin
            kill_d  = 1'b1;
            state_d = S_DRAIN;
          end else begin
            state_d = S_WAIT;
          end
        end else if (flush_i) begin
          kill_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (sel_dout_valid) begin
          if (flush_i) begin
            state_d = S_IDLE;
          end else begin
            quo_d   = sel_dout[2*DW-1:DW];
            rem_d   = sel_dout[DW-1:0];
            state_d = S_DONE;
          end
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (flush_i || res_ack_i) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (sel_dout_valid) begin
          kill_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o        = (state_q != S_IDLE);
  assign res_valid_o   = (state_q == S_DONE);
  assign res_data_o    = mod_q ? rem_q : quo_q;
  assign div_src1_o    = src1_q;
  assign div_src2_o    = src2_q;
  assign sdiv_tvalid_o = (state_q == S_ISSUE) && signed_q;
  assign udiv_tvalid_o = (state_q == S_ISSUE) && !signed_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural model of the two divider cores.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_signed, req_mod;
  logic [31:0] req_src1, req_src2;
  logic        flush, res_ack;
  logic        res_valid;
  logic [31:0] res_data;
  logic        busy;
  logic [31:0] div_src1, div_src2;
  logic        sdiv_tvalid, udiv_tvalid;
  logic        sdiv_tready, udiv_tready;
  logic        sdiv_dout_valid, udiv_dout_valid;
  logic [63:0] sdiv_dout, udiv_dout;

  logic        tready_en;
  int          ip_lat;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  div_sequencer dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid_i       (req_valid),
    .req_signed_i      (req_signed),
    .req_mod_i         (req_mod),
    .req_src1_i        (req_src1),
    .req_src2_i        (req_src2),
    .flush_i           (flush),
    .res_ack_i         (res_ack),
    .res_valid_o       (res_valid),
    .res_data_o        (res_data),
    .busy_o            (busy),
    .div_src1_o        (div_src1),
    .div_src2_o        (div_src2),
    .sdiv_tvalid_o     (sdiv_tvalid),
    .udiv_tvalid_o     (udiv_tvalid),
    .sdiv_tready_i     (sdiv_tready),
    .udiv_tready_i     (udiv_tready),
    .sdiv_dout_valid_i (sdiv_dout_valid),
    .udiv_dout_valid_i (udiv_dout_valid),
    .sdiv_dout_i       (sdiv_dout),
    .udiv_dout_i       (udiv_dout)
  );

  assign sdiv_tready = tready_en;
  assign udiv_tready = tready_en;

  function automatic logic [63:0] sdiv_f(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return {32'hFFFFFFFF, a};
    return {32'(sa / sb), 32'(sa % sb)};
  endfunction

  function automatic logic [63:0] udiv_f(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return {32'hFFFFFFFF, a};
    return {a / b, a % b};
  endfunction

  // Core model: accepts on tvalid&tready, returns one dout_valid pulse ip_lat edges later.
  logic        core_busy;
  logic        core_signed;
  int          core_cnt;
  logic [63:0] core_res;

  always @(posedge clk) begin
    sdiv_dout_valid <= 1'b0;
    udiv_dout_valid <= 1'b0;
    if (reset) begin
      core_busy <= 1'b0;
      core_cnt  <= 0;
      sdiv_dout <= '0;
      udiv_dout <= '0;
    end else if (core_busy) begin
      if (core_cnt == 0) begin
        core_busy <= 1'b0;
        if (core_signed) begin
          sdiv_dout_valid <= 1'b1;
          sdiv_dout       <= core_res;
        end else begin
          udiv_dout_valid <= 1'b1;
          udiv_dout       <= core_res;
        end
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end else if (sdiv_tvalid && sdiv_tready) begin
      core_busy   <= 1'b1;
      core_signed <= 1'b1;
      core_cnt    <= ip_lat - 1;
      core_res    <= sdiv_f(div_src1, div_src2);
    end else if (udiv_tvalid && udiv_tready) begin
      core_busy   <= 1'b1;
      core_signed <= 1'b0;
      core_cnt    <= ip_lat - 1;
      core_res    <= udiv_f(div_src1, div_src2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one edge; returns 1 ns after the sampling edge.
  task automatic do_req(input logic sgn, input logic md, input logic [31:0] a, input logic [31:0] b);
    req_valid  = 1'b1;
    req_signed = sgn;
    req_mod    = md;
    req_src1   = a;
    req_src2   = b;
    step();
    req_valid  = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (res_valid) begin
        got = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic do_ack();
    res_ack = 1'b1;
    step();
    res_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (res_data !== 32'h0) begin n_fail++; $display("FAIL reset_res_data got=%h exp=0", res_data); end
    n_checks++; if ({sdiv_tvalid, udiv_tvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_tvalid got=%b exp=00", {sdiv_tvalid, udiv_tvalid}); end
    n_checks++; if ({div_src1, div_src2} !== 64'h0) begin n_fail++; $display("FAIL reset_src got=%h exp=0", {div_src1, div_src2}); end
  endtask

  task automatic test_signed();
    bit got;
    do_req(1'b1, 1'b0, 32'd7, 32'hFFFFFFFE);
    n_checks++; if ({sdiv_tvalid, udiv_tvalid} !== 2'b10) begin n_fail++; $display("FAIL signed_tvalid got=%b exp=10", {sdiv_tvalid, udiv_tvalid}); end
    wait_valid(got);
    n_checks++; if (!got) begin n_fail++; $display("FAIL signed_div_timeout got=0 exp=1"); end
    n_checks++; if (res_data !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL signed_div got=%h exp=fffffffd", res_data); end
    do_ack();
    do_req(1'b1, 1'b1, 32'd7, 32'hFFFFFFFE);
    wait_valid(got);
    n_checks++; if (!got || res_data !== 32'h1) begin n_fail++; $display("FAIL signed_mod got=%h valid=%b exp=00000001", res_data, got); end
    do_ack();
  endtask

  task automatic test_unsigned();
    bit got;
    do_req(1'b0, 1'b0, 32'hFFFFFFFF, 32'd2);
    n_checks++; if ({sdiv_tvalid, udiv_tvalid} !== 2'b01) begin n_fail++; $display("FAIL unsigned_tvalid got=%b exp=01", {sdiv_tvalid, udiv_tvalid}); end
    wait_valid(got);
    n_checks++; if (!got || res_data !== 32'h7FFFFFFF) begin n_fail++; $display("FAIL unsigned_div got=%h valid=%b exp=7fffffff", res_data, got); end
    do_ack();
    do_req(1'b0, 1'b1, 32'hFFFFFFFF, 32'd2);
    wait_valid(got);
    n_checks++; if (!got || res_data !== 32'h1) begin n_fail++; $display("FAIL unsigned_mod got=%h valid=%b exp=00000001", res_data, got); end
    do_ack();
  endtask

  task automatic test_tready_stall();
    bit got;
    tready_en = 1'b0;
    do_req(1'b0, 1'b0, 32'd50, 32'd5);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (udiv_tvalid !== 1'b1 || div_src1 !== 32'd50 || div_src2 !== 32'd5) begin
        n_fail++;
        $display("FAIL stall_hold cyc=%0d got tvalid=%b src1=%h src2=%h exp 1/32/5", i, udiv_tvalid, div_src1, div_src2);
      end
      if (i < 2) step();
    end
    tready_en = 1'b1;
    step();
    n_checks++; if (udiv_tvalid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL stall_proceed got tvalid=%b busy=%b exp 0/1", udiv_tvalid, busy); end
    wait_valid(got);
    n_checks++; if (!got || res_data !== 32'd10) begin n_fail++; $display("FAIL stall_result got=%h valid=%b exp=0000000a", res_data, got); end
    do_ack();
  endtask

  task automatic test_flush_wait();
    bit got;
    bit saw;
    ip_lat = 4;
    do_req(1'b1, 1'b0, 32'd1000, 32'd3);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++; if (busy !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL flush_wait_drain got busy=%b valid=%b exp 1/0", busy, res_valid); end
    saw = 1'b0;
    for (int i = 0; i < 40 && busy; i++) begin
      if (res_valid) saw = 1'b1;
      step();
    end
    n_checks++; if (busy !== 1'b0 || saw) begin n_fail++; $display("FAIL flush_wait_idle got busy=%b saw_valid=%b exp 0/0", busy, saw); end
    ip_lat = 2;
    do_req(1'b1, 1'b0, 32'd100, 32'd7);
    wait_valid(got);
    n_checks++; if (!got || res_data !== 32'd14) begin n_fail++; $display("FAIL flush_next got=%h valid=%b exp=0000000e", res_data, got); end
    do_ack();
  endtask

  task automatic test_flush_issue();
    bit saw;
    tready_en = 1'b0;
    do_req(1'b1, 1'b0, 32'd77, 32'd4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_checks++; if (sdiv_tvalid !== 1'b1) begin n_fail++; $display("FAIL flush_issue_tvalid got=%b exp=1", sdiv_tvalid); end
    tready_en = 1'b1;
    step();
    n_checks++; if (busy !== 1'b1 || res_valid !== 1'b0 || sdiv_tvalid !== 1'b0) begin n_fail++; $display("FAIL flush_issue_drain got busy=%b valid=%b tvalid=%b exp 1/0/0", busy, res_valid, sdiv_tvalid); end
    saw = 1'b0;
    for (int i = 0; i < 40 && busy; i++) begin
      if (res_valid) saw = 1'b1;
      step();
    end
    n_checks++; if (busy !== 1'b0 || saw) begin n_fail++; $display("FAIL flush_issue_idle got busy=%b saw_valid=%b exp 0/0", busy, saw); end
  endtask

  task automatic test_hold();
    bit got;
    do_req(1'b0, 1'b0, 32'd91, 32'd13);
    wait_valid(got);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== 32'd7) begin n_fail++; $display("FAIL hold cyc=%0d got valid=%b data=%h exp 1/00000007", i, res_valid, res_data); end
      step();
    end
    flush   = 1'b1;
    res_ack = 1'b1;
    step();
    flush   = 1'b0;
    res_ack = 1'b0;
    n_checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_ack got valid=%b busy=%b exp 0/0", res_valid, busy); end
  endtask

  task automatic test_back_to_back();
    bit got;
    do_req(1'b1, 1'b1, 32'hFFFFFF9C, 32'd7);
    wait_valid(got);
    n_checks++; if (!got || res_data !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL b2b_first got=%h valid=%b exp=fffffffe", res_data, got); end
    res_ack    = 1'b1;
    req_valid  = 1'b1;
    req_signed = 1'b0;
    req_mod    = 1'b0;
    req_src1   = 32'd1000;
    req_src2   = 32'd10;
    step();
    res_ack = 1'b0;
    n_checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle got valid=%b busy=%b exp 0/0", res_valid, busy); end
    step();
    req_valid = 1'b0;
    n_checks++; if (udiv_tvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_issue got=%b exp=1", udiv_tvalid); end
    wait_valid(got);
    n_checks++; if (!got || res_data !== 32'd100) begin n_fail++; $display("FAIL b2b_second got=%h valid=%b exp=00000064", res_data, got); end
    do_ack();
  endtask

`ifdef DIV_CACHE_EN
  task automatic test_cache();
    bit got;
    do_req(1'b1, 1'b0, 32'd100, 32'd7);
    wait_valid(got);
    n_checks++; if (!got || res_data !== 32'd14) begin n_fail++; $display("FAIL cache_div got=%h valid=%b exp=0000000e", res_data, got); end
    do_ack();
    do_req(1'b1, 1'b1, 32'd100, 32'd7);
    n_checks++; if (res_valid !== 1'b1 || res_data !== 32'd2) begin n_fail++; $display("FAIL cache_mod got valid=%b data=%h exp 1/00000002", res_valid, res_data); end
    n_checks++; if ({sdiv_tvalid, udiv_tvalid} !== 2'b00) begin n_fail++; $display("FAIL cache_tvalid got=%b exp=00", {sdiv_tvalid, udiv_tvalid}); end
    do_ack();
  endtask
`endif

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_signed = 1'b0;
    req_mod    = 1'b0;
    req_src1   = '0;
    req_src2   = '0;
    flush      = 1'b0;
    res_ack    = 1'b0;
    tready_en  = 1'b1;
    ip_lat     = 2;
    test_reset();
    test_signed();
    test_unsigned();
    test_tready_stall();
    test_flush_wait();
    test_flush_issue();
    test_hold();
    test_back_to_back();
`ifdef DIV_CACHE_EN
    test_cache();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
